// File: rtl/intdiv_iter_pkg.sv
// Shared configuration struct, divider FSM states and the M-extension
// Funct3 encodings that the decoder and the divider agree on.
package cvw;

  typedef struct packed {
    int XLEN;
    int IDIV_BITSPERCYCLE;
  } cvw_t;

  localparam cvw_t DEFAULT_CFG = '{XLEN: 64, IDIV_BITSPERCYCLE: 1};

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } div_state_e;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/intdiv_iter_step.sv
// One combinational restoring-division step: shift one dividend bit into the
// partial remainder, trial-subtract the divisor, and shift out a quotient bit.
module intdiv_step import cvw::*; #(
  parameter int W = 64
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] div_in,
  output logic [W:0]   rem_out,
  output logic [W-1:0] x_out
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         q_bit;
  logic         unused_rem_msb;

  // The remainder stays below the divisor, so its top bit is always clear here.
  always_comb begin
    shifted = {rem_in[W-1:0], x_in[W-1]};
    diff    = {1'b0, shifted} - {2'b00, div_in};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted;
    x_out   = {x_in[W-2:0], q_bit};
  end

  assign unused_rem_msb = rem_in[W];

endmodule

// File: rtl/intdiv_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and the RV64 word forms,
// retiring IDIV_BITSPERCYCLE quotient bits per cycle.
module intdiv_iter import cvw::*; #(
  parameter cvw_t P = DEFAULT_CFG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Flush,
  input  logic [2:0]        Funct3,
  input  logic              W64,
  input  logic [P.XLEN-1:0] SrcA,
  input  logic [P.XLEN-1:0] SrcB,
  output logic              Ready,
  output logic              Busy,
  output logic              Done,
  output logic [P.XLEN-1:0] Result
);

  localparam int XLEN  = P.XLEN;
  localparam int BPC   = P.IDIV_BITSPERCYCLE;
  localparam int CNT_W = $clog2(XLEN);
  localparam int HALF  = XLEN / 2;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  x_q, x_d, div_q, div_d, result_q, result_d;
  logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic             is_rem_q, is_rem_d, w_q, w_d;

  logic             w_op, op_signed, op_rem, a_neg, b_neg;
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, a_sx, min_val;

  // Word ops work on the low 32 bits, extended so one datapath serves both widths.
  always_comb begin
    w_op      = (XLEN == 64) && W64;
    op_signed = (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    op_rem    = (Funct3 == F3_REM) || (Funct3 == F3_REMU);
    a_sx      = XLEN'($signed(SrcA[31:0]));
    if (w_op) begin
      a_ext   = op_signed ? a_sx : XLEN'(SrcA[31:0]);
      b_ext   = op_signed ? XLEN'($signed(SrcB[31:0])) : XLEN'(SrcB[31:0]);
      min_val = XLEN'($signed(32'h8000_0000));
    end else begin
      a_ext   = SrcA;
      b_ext   = SrcB;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg = op_signed & a_ext[XLEN-1];
    b_neg = op_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  logic [XLEN:0]   rem_chain [BPC+1];
  logic [XLEN-1:0] x_chain   [BPC+1];

  assign rem_chain[0] = rem_q;
  assign x_chain[0]   = x_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    intdiv_step #(.W(XLEN)) u_step (
      .rem_in  (rem_chain[i]),
      .x_in    (x_chain[i]),
      .div_in  (div_q),
      .rem_out (rem_chain[i+1]),
      .x_out   (x_chain[i+1])
    );
  end

  logic [XLEN-1:0] res_raw, res_neg, res_fin;
  logic            unused_chain_msb;

  always_comb begin
    res_raw = is_rem_q ? rem_chain[BPC][XLEN-1:0] : x_chain[BPC];
    res_neg = (is_rem_q ? rem_neg_q : quo_neg_q) ? -res_raw : res_raw;
    res_fin = w_q ? XLEN'($signed(res_neg[31:0])) : res_neg;
  end

  assign unused_chain_msb = rem_chain[BPC][XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    x_d       = x_q;
    div_d     = div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    is_rem_d  = is_rem_q;
    w_d       = w_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          // Word dividends start in the upper half so the MSB-first steps see them first.
          rem_d     = '0;
          x_d       = w_op ? (a_mag << HALF) : a_mag;
          div_d     = b_mag;
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          is_rem_d  = op_rem;
          w_d       = w_op;
          cnt_d     = CNT_W'((w_op ? 32 : XLEN) / BPC - 1);
          if (b_ext == '0) begin
            result_d = op_rem ? (w_op ? a_sx : SrcA) : '1;
            state_d  = DONE;
          end else if (op_signed && (a_ext == min_val) && (b_ext == '1)) begin
            result_d = op_rem ? '0 : a_ext;
            state_d  = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d = rem_chain[BPC];
        x_d   = x_chain[BPC];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          result_d = res_fin;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      x_q       <= '0;
      div_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      is_rem_q  <= 1'b0;
      w_q       <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      x_q       <= x_d;
      div_q     <= div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      is_rem_q  <= is_rem_d;
      w_q       <= w_d;
      result_q  <= result_d;
    end
  end

  assign Ready  = (state_q == IDLE);
  assign Busy   = (state_q != IDLE);
  assign Done   = (state_q == DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_intdiv_iter.sv
// Directed bench driving three RV64 dividers (1, 2 and 4 bits per cycle) in
// lockstep; expected results and latencies are hand-computed constants.
module tb_intdiv_iter;
  import cvw::*;

  localparam cvw_t CFG_BPC1 = '{XLEN: 64, IDIV_BITSPERCYCLE: 1};
  localparam cvw_t CFG_BPC2 = '{XLEN: 64, IDIV_BITSPERCYCLE: 2};
  localparam cvw_t CFG_BPC4 = '{XLEN: 64, IDIV_BITSPERCYCLE: 4};

  logic        clk = 1'b0;
  logic        reset, Start, Flush, W64;
  logic [2:0]  Funct3;
  logic [63:0] SrcA, SrcB;
  logic        ready [3];
  logic        busy  [3];
  logic        done  [3];
  logic [63:0] result [3];

  int          total = 0;
  int          bad = 0;
  int          bpc_of [3] = '{1, 2, 4};
  int          pulses [3];
  logic [63:0] last_res;

  always #5 clk = ~clk;

  intdiv_iter #(.P(CFG_BPC1)) u_bpc1 (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3), .W64(W64),
    .SrcA(SrcA), .SrcB(SrcB), .Ready(ready[0]), .Busy(busy[0]), .Done(done[0]), .Result(result[0])
  );

  intdiv_iter #(.P(CFG_BPC2)) u_bpc2 (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3), .W64(W64),
    .SrcA(SrcA), .SrcB(SrcB), .Ready(ready[1]), .Busy(busy[1]), .Done(done[1]), .Result(result[1])
  );

  intdiv_iter #(.P(CFG_BPC4)) u_bpc4 (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3), .W64(W64),
    .SrcA(SrcA), .SrcB(SrcB), .Ready(ready[2]), .Busy(busy[2]), .Done(done[2]), .Result(result[2])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  task automatic startOp(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    Funct3 = f3;
    W64    = w;
    SrcA   = a;
    SrcB   = b;
    Start  = 1'b1;
  endtask

  task automatic countDone();
    for (int i = 0; i < 3; i++) if (done[i]) pulses[i]++;
  endtask

  // Cycle c is counted from the Start cycle (c=0); operands are scrambled after
  // acceptance and a stray Start is issued mid-iteration, neither may disturb the op.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic w,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp_res, input int l1, input int l2, input int l4);
    int          exp_lat [3];
    int          lat [3];
    int          cnt [3];
    logic [63:0] got [3];
    exp_lat = '{l1, l2, l4};
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      cnt[i] = 0;
      got[i] = '0;
    end
    startOp(f3, w, a, b);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) begin
        Start = 1'b0;
        SrcA  = ~a;
        SrcB  = ~b;
      end
      if (c == 5 && l4 > 7) Start = 1'b1;
      if (c == 6) Start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          cnt[i]++;
          if (lat[i] < 0) begin
            lat[i] = c;
            got[i] = result[i];
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s/bpc%0d/latency", tag, bpc_of[i]), 64'(lat[i]), 64'(exp_lat[i]));
      checkOutput($sformatf("%s/bpc%0d/result", tag, bpc_of[i]), got[i], exp_res);
      checkOutput($sformatf("%s/bpc%0d/pulses", tag, bpc_of[i]), 64'(cnt[i]), 64'd1);
      checkOutput($sformatf("%s/bpc%0d/held", tag, bpc_of[i]), result[i], exp_res);
      checkOutput($sformatf("%s/bpc%0d/ready", tag, bpc_of[i]), 64'(ready[i]), 64'd1);
    end
    last_res = exp_res;
  endtask

  initial begin
    reset  = 1'b1;
    Start  = 1'b0;
    Flush  = 1'b0;
    Funct3 = F3_DIVU;
    W64    = 1'b0;
    SrcA   = '0;
    SrcB   = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset/bpc%0d/ready", bpc_of[i]), 64'(ready[i]), 64'd1);
      checkOutput($sformatf("reset/bpc%0d/busy", bpc_of[i]), 64'(busy[i]), 64'd0);
      checkOutput($sformatf("reset/bpc%0d/done", bpc_of[i]), 64'(done[i]), 64'd0);
      checkOutput($sformatf("reset/bpc%0d/result", bpc_of[i]), result[i], 64'd0);
    end
    reset = 1'b0;

    applyStimulus("divu_100_7", F3_DIVU, 0, 100, 7, 14, 65, 33, 17);
    applyStimulus("remu_100_7", F3_REMU, 0, 100, 7, 2, 65, 33, 17);
    applyStimulus("rem_m7_2", F3_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 33, 17);
    applyStimulus("div_m7_2", F3_DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 33, 17);
    applyStimulus("div_m100_7", F3_DIV, 0, 64'hFFFF_FFFF_FFFF_FF9C, 7, 64'hFFFF_FFFF_FFFF_FFF2, 65, 33, 17);
    applyStimulus("rem_m100_7", F3_REM, 0, 64'hFFFF_FFFF_FFFF_FF9C, 7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 33, 17);
    applyStimulus("divu_big", F3_DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 65, 33, 17);
    applyStimulus("remu_big", F3_REMU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 65, 33, 17);
    applyStimulus("div_min_min", F3_DIV, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 65, 33, 17);
    applyStimulus("rem_7_min", F3_REM, 0, 7, 64'h8000_0000_0000_0000, 7, 65, 33, 17);
    applyStimulus("div_5_0", F3_DIV, 0, 5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1);
    applyStimulus("remu_5_0", F3_REMU, 0, 5, 0, 5, 1, 1, 1);
    applyStimulus("div_ovf", F3_DIV, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1, 1);
    applyStimulus("rem_ovf", F3_REM, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 1);
    applyStimulus("divw_ovf", F3_DIV, 1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1, 1);
    applyStimulus("divuw", F3_DIVU, 1, 64'h0000_0000_FFFF_FFFF, 2, 64'h0000_0000_7FFF_FFFF, 33, 17, 9);
    applyStimulus("remw_m7_2", F3_REM, 1, 64'hDEAD_BEEF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 17, 9);
    applyStimulus("remuw_mask", F3_REMU, 1, 64'hAAAA_AAAA_FFFF_FFFF, 64'h0000_0001_0000_0010, 64'hF, 33, 17, 9);
    applyStimulus("remw_div0", F3_REM, 1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, 1, 1);

    // Flush in cycle 10 of a long DIVU: idle next cycle, no Done, Result untouched.
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    startOp(F3_DIVU, 0, 100, 7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) Start = 1'b0;
      if (c == 10) Flush = 1'b1;
      countDone();
    end
    @(negedge clk);
    Flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("flush/bpc%0d/ready", bpc_of[i]), 64'(ready[i]), 64'd1);
      checkOutput($sformatf("flush/bpc%0d/busy", bpc_of[i]), 64'(busy[i]), 64'd0);
    end
    for (int c = 0; c < 70; c++) begin
      countDone();
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("flush/bpc%0d/pulses", bpc_of[i]), 64'(pulses[i]), 64'd0);
      checkOutput($sformatf("flush/bpc%0d/result", bpc_of[i]), result[i], last_res);
    end

    // Flush and Start together while idle: the Start must be dropped.
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    Funct3 = F3_DIV;
    W64    = 1'b0;
    SrcA   = 5;
    SrcB   = 0;
    Start  = 1'b1;
    Flush  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        Start = 1'b0;
        Flush = 1'b0;
      end
      countDone();
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("flush_start/bpc%0d/pulses", bpc_of[i]), 64'(pulses[i]), 64'd0);
      checkOutput($sformatf("flush_start/bpc%0d/ready", bpc_of[i]), 64'(ready[i]), 64'd1);
      checkOutput($sformatf("flush_start/bpc%0d/result", bpc_of[i]), result[i], last_res);
    end

    // Asynchronous reset mid-operation takes effect without waiting for a clock edge.
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    startOp(F3_DIVU, 0, 100, 7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) Start = 1'b0;
      countDone();
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("midreset/bpc%0d/ready", bpc_of[i]), 64'(ready[i]), 64'd1);
      checkOutput($sformatf("midreset/bpc%0d/busy", bpc_of[i]), 64'(busy[i]), 64'd0);
      checkOutput($sformatf("midreset/bpc%0d/done", bpc_of[i]), 64'(done[i]), 64'd0);
      checkOutput($sformatf("midreset/bpc%0d/result", bpc_of[i]), result[i], 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      countDone();
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("midreset/bpc%0d/pulses", bpc_of[i]), 64'(pulses[i]), 64'd0);

    applyStimulus("divu_9_3", F3_DIVU, 0, 9, 3, 3, 65, 33, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
